// File: rtl/accumulator.sv
// Groups COUNT consecutive X items into one summed Y result behind a one-entry output buffer.
// Optional build macro ACCUMULATOR_SAT_EN clamps every add to the SUM_WIDTH maximum instead of wrapping.
module accumulator #(
   parameter int WIDTH     = 8,
   parameter int SUM_WIDTH = 10,
   parameter int COUNT     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 X_valid,
   output logic                 X_ready,
   input  logic [WIDTH-1:0]     X_data,
   output logic                 Y_valid,
   input  logic                 Y_ready,
   output logic [SUM_WIDTH-1:0] Y_data
);

   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SUM_WIDTH-1:0] sum_q, sum_d;
   logic [SUM_WIDTH-1:0] y_data_q, y_data_d;
   logic                 y_valid_q, y_valid_d;
   logic                 last, y_ok, x_fire;
   logic [SUM_WIDTH-1:0] add_res;

`ifdef ACCUMULATOR_SAT_EN
   logic [SUM_WIDTH:0] add_wide;
   assign add_wide = {1'b0, sum_q} + (SUM_WIDTH+1)'(X_data);
   // Once clamped, later adds exceed the max again, so saturation sticks for the group.
   assign add_res  = add_wide[SUM_WIDTH] ? '1 : add_wide[SUM_WIDTH-1:0];
`else
   assign add_res  = sum_q + SUM_WIDTH'(X_data);
`endif

   assign last    = (cnt_q == LAST_CNT);
   assign y_ok    = !y_valid_q || Y_ready;
   assign X_ready = !last || y_ok;
   assign x_fire  = X_valid && X_ready;

   always_comb begin
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      y_data_d  = y_data_q;
      y_valid_d = y_valid_q;
      if (y_valid_q && Y_ready) begin
         y_valid_d = 1'b0;
      end
      // A final-item load overrides the drain so back-to-back groups leave no bubble.
      if (x_fire) begin
         if (last) begin
            y_data_d  = add_res;
            y_valid_d = 1'b1;
            sum_d     = '0;
            cnt_d     = '0;
         end else begin
            sum_d = add_res;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         sum_q     <= '0;
         y_data_q  <= '0;
         y_valid_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         y_data_q  <= y_data_d;
         y_valid_q <= y_valid_d;
      end
   end

   assign Y_valid = y_valid_q;
   assign Y_data  = y_data_q;

endmodule
